fp_mant_div_seq: RTL and testbench

FP_MANT_DIV_SEQ -- requirements
Module: fp_mant_div_seq

---
 rtl/fpu_pkg.sv | 12 +
 rtl/fp_mant_div_seq_if.sv | 25 ++
 rtl/mant_div_step.sv | 23 ++
 rtl/fp_mant_div_seq.sv | 87 ++++++++
 tb/tb_fp_mant_div_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the FP mantissa divider.
package fpu_pkg;
   localparam int MANT_W = 52;
   localparam int QW     = MANT_W + 3;
   localparam int CNT_W  = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;
endpackage

// File: rtl/fp_mant_div_seq_if.sv
// Request/result bundle between the FP divide sequencer and the mantissa divider.
interface fp_mant_div_seq_if #(
   parameter int MANT_W = fpu_pkg::MANT_W
);
   localparam int QW = MANT_W + 3;

   logic              start;
   logic              flush;
   logic [MANT_W-1:0] m1;
   logic [MANT_W-1:0] m2;
   logic              busy;
   logic              done;
   logic [QW-1:0]     q;
   logic              sticky;

   modport master (
      output start, flush, m1, m2,
      input  busy, done, q, sticky
   );

   modport slave (
      input  start, flush, m1, m2,
      output busy, done, q, sticky
   );
endinterface

// File: rtl/mant_div_step.sv
// One restoring-division step: compare, conditional subtract, shift left.
module mant_div_step
   import fpu_pkg::*;
#(
   parameter int QW = fpu_pkg::QW
) (
   input  logic [QW-1:0] r_i,
   input  logic [QW-1:0] d_i,
   output logic          bit_o,
   output logic [QW-1:0] r_o,
   output logic          rem_nz_o
);
   logic [QW-1:0] diff;
   logic [QW-1:0] rem;

   always_comb begin
      bit_o    = (r_i >= d_i);
      diff     = r_i - d_i;
      rem      = bit_o ? diff : r_i;
      r_o      = rem << 1;
      rem_nz_o = |rem;
   end
endmodule

// File: rtl/fp_mant_div_seq.sv
// Sequential restoring mantissa divider: one quotient bit per cycle, MSB first.
module fp_mant_div_seq
   import fpu_pkg::*;
#(
   parameter int MANT_W = fpu_pkg::MANT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   fp_mant_div_seq_if.slave     dv
);
   localparam int QW = MANT_W + 3;

   div_state_e       state_q;
   logic [QW-1:0]    r_q;
   logic [QW-1:0]    d_q;
   logic [QW-1:0]    q_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sticky_q;
   logic             busy_q;
   logic             done_q;

   logic             qbit_d;
   logic [QW-1:0]    r_d;
   logic             rem_nz_d;

   mant_div_step #(.QW(QW)) u_step (
      .r_i      (r_q),
      .d_i      (d_q),
      .bit_o    (qbit_d),
      .r_o      (r_d),
      .rem_nz_o (rem_nz_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         r_q      <= '0;
         d_q      <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (dv.flush) begin
         state_q  <= IDLE;
         q_q      <= '0;
         sticky_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               r_q <= r_d;
               q_q <= {q_q[QW-2:0], qbit_d};
               if (cnt_q == '0) begin
                  sticky_q <= rem_nz_d;
                  state_q  <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept a new request; done is only ever one cycle.
               done_q <= 1'b0;
               if (dv.start) begin
                  d_q      <= {{(QW-MANT_W-1){1'b0}}, 1'b1, dv.m2};
                  r_q      <= {{(QW-MANT_W-1){1'b0}}, 1'b1, dv.m1};
                  q_q      <= '0;
                  sticky_q <= 1'b0;
                  cnt_q    <= CNT_W'(QW-1);
                  state_q  <= RUN;
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= IDLE;
               end
            end
         endcase
      end
   end

   assign dv.busy   = busy_q;
   assign dv.done   = done_q;
   assign dv.q      = q_q;
   assign dv.sticky = sticky_q;
endmodule

// File: tb/tb_fp_mant_div_seq.sv
// Directed-vector bench for the sequential mantissa divider.
module tb_fp_mant_div_seq;
   import fpu_pkg::*;

   localparam int MW  = MANT_W;
   localparam int TQW = MW + 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fp_mant_div_seq_if #(.MANT_W(MW)) dv ();

   fp_mant_div_seq #(.MANT_W(MW)) dut (
      .clk (clk),
      .rst (rst),
      .dv  (dv)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_busy"},   64'(dv.busy),   64'd0);
      check_eq({tag, "_done"},   64'(dv.done),   64'd0);
      check_eq({tag, "_q"},      64'(dv.q),      64'd0);
      check_eq({tag, "_sticky"}, 64'(dv.sticky), 64'd0);
   endtask

   // Single op with inputs scrambled and a stray start pulse mid-RUN.
   task automatic run_op(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic [TQW-1:0] eq, input logic es);
      int n;
      int nbusy;
      bit seen;
      dv.m1 = a;
      dv.m2 = b;
      dv.start = 1'b1;
      tick();
      dv.start = 1'b0;
      dv.m1 = ~a;
      dv.m2 = ~b;
      n = 0;
      nbusy = dv.busy ? 1 : 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         if (n == 10) dv.start = 1'b1;
         if (n == 11) dv.start = 1'b0;
         tick();
         n++;
         if (dv.done) seen = 1'b1;
         else if (dv.busy) nbusy++;
      end
      check_eq({tag, "_lat"},    64'(n),         64'd55);
      check_eq({tag, "_busyc"},  64'(nbusy),     64'd55);
      check_eq({tag, "_q"},      64'(dv.q),      64'(eq));
      check_eq({tag, "_sticky"}, 64'(dv.sticky), 64'(es));
      tick();
      check_eq({tag, "_pulse"},  64'(dv.done),   64'd0);
      check_eq({tag, "_hold"},   64'(dv.q),      64'(eq));
   endtask

   logic [MW-1:0]  va [3];
   logic [MW-1:0]  vb [3];
   logic [TQW-1:0] vq [3];
   logic           vs [3];
   int             ndone;
   int             n;
   bit             seen;

   initial begin
      va[0] = 52'h8000000000000; vb[0] = 52'h0;             vq[0] = 55'h60000000000000; vs[0] = 1'b0;
      va[1] = 52'h0;             vb[1] = 52'h8000000000000; vq[1] = 55'h2AAAAAAAAAAAAA; vs[1] = 1'b1;
      va[2] = 52'h0;             vb[2] = 52'h0;             vq[2] = 55'h40000000000000; vs[2] = 1'b0;

      dv.start = 1'b0;
      dv.flush = 1'b0;
      dv.m1 = '0;
      dv.m2 = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset");

      run_op("one_one",   52'h0,             52'h0,             55'h40000000000000, 1'b0);
      run_op("p5_one",    52'h8000000000000, 52'h0,             55'h60000000000000, 1'b0);
      run_op("one_p5",    52'h0,             52'h8000000000000, 55'h2AAAAAAAAAAAAA, 1'b1);
      run_op("one_max",   52'h0,             52'hFFFFFFFFFFFFF, 55'h20000000000001, 1'b1);
      run_op("max_one",   52'hFFFFFFFFFFFFF, 52'h0,             55'h7FFFFFFFFFFFFC, 1'b0);
      run_op("p5_p5",     52'h8000000000000, 52'h8000000000000, 55'h40000000000000, 1'b0);

      // Flush part-way through a divide.
      dv.m1 = 52'h0;
      dv.m2 = 52'h8000000000000;
      dv.start = 1'b1;
      tick();
      dv.start = 1'b0;
      repeat (19) tick();
      dv.flush = 1'b1;
      tick();
      dv.flush = 1'b0;
      check_idle("flush_run");
      ndone = 0;
      repeat (60) begin
         tick();
         if (dv.done || dv.busy) ndone++;
      end
      check_eq("flush_quiet", 64'(ndone), 64'd0);

      // Reset part-way through a divide.
      dv.start = 1'b1;
      tick();
      dv.start = 1'b0;
      repeat (29) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_run");
      ndone = 0;
      repeat (60) begin
         tick();
         if (dv.done || dv.busy) ndone++;
      end
      check_eq("rst_quiet", 64'(ndone), 64'd0);

      run_op("after_abort", 52'h0, 52'h0, 55'h40000000000000, 1'b0);
      run_op("pre_fl_idle", 52'h0, 52'h8000000000000, 55'h2AAAAAAAAAAAAA, 1'b1);

      // Flush wins over start while idle, and clears the held result.
      dv.flush = 1'b1;
      dv.start = 1'b1;
      tick();
      dv.flush = 1'b0;
      dv.start = 1'b0;
      check_idle("flush_idle");
      tick();
      check_eq("flush_idle_nostart", 64'(dv.busy), 64'd0);

      // Start held high: back-to-back ops, inputs scrambled while running.
      dv.m1 = va[0];
      dv.m2 = vb[0];
      dv.start = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         dv.m1 = ~va[k];
         dv.m2 = ~vb[k];
         n = 0;
         seen = 1'b0;
         while (!seen && n < 100) begin
            tick();
            n++;
            if (n == 40) begin
               if (k < 2) begin
                  dv.m1 = va[k+1];
                  dv.m2 = vb[k+1];
               end else begin
                  dv.start = 1'b0;
               end
            end
            if (dv.done) seen = 1'b1;
         end
         check_eq($sformatf("b2b%0d_lat", k),    64'(n),         64'd55);
         check_eq($sformatf("b2b%0d_q", k),      64'(dv.q),      64'(vq[k]));
         check_eq($sformatf("b2b%0d_sticky", k), 64'(dv.sticky), 64'(vs[k]));
         tick();
         check_eq($sformatf("b2b%0d_pulse", k),  64'(dv.done),   64'd0);
         check_eq($sformatf("b2b%0d_busy", k),   64'(dv.busy),   (k < 2) ? 64'd1 : 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
